obstacle_scroller: RTL
======================

// Module: obstacle_scroller
// PURPOSE
//  Drives the single on-screen obstacle for the level controller.
//  - Advances obj_count once per frame tick across one pass (0..PASS_END).
//  - Flags the end of each pass with obj_count == PASS_END held for exactly one clk.
//  - Detects player/obstacle overlap and issues a one-clk hit pulse.
//  - Sits directly upstream of the level state machine, which consumes obj_count and hit.
// PARAMETERS
//  PASS_END    695  final obj_count value of a pass; held exactly one clk
//  STEP        1    obj_count increment per frame_tick
//  MAX_STEP    8    step ceiling (used only with OBSTACLE_SPEEDUP_EN)
//  X_START     640  obstacle left-edge x when obj_count == 0; obj_x = X_START - obj_count
//  OBJ_W       20   obstacle width, px
//  OBJ_TOP     440  obstacle top y; player collides when player_bottom > OBJ_TOP
//  PLAYER_X    80   player left-edge x (fixed)
//  PLAYER_W    20   player width, px
//  HOLD_FRAMES 60   frames frozen after a hit
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  frame_tick     in   1   one-clk pulse per video frame
//  start          in   1   level pulse; leaves IDLE
//  player_bottom  in   10  player bottom-edge y, px (jumping = smaller)
//  obj_count      out  11  pass progress, 0..PASS_END
//  obj_x          out  11  signed-safe obstacle left x (X_START - obj_count, 2's complement)
//  hit            out  1   one-clk collision pulse
//  pass_count     out  8   completed passes since last hit, saturates at 255
//  busy           out  1   high in RUN/WRAP
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE.
//    - Reset values: obj_count=0, hit=0, pass_count=0, busy=0, step=STEP.
//  - States: IDLE, RUN, WRAP, HIT, HOLD (2-3 bit enum).
//  - IDLE:
//    - obj_count=0.
//    - On start go to RUN next clk.
//    - frame_tick ignored.
//  - RUN, on frame_tick:
//    - Evaluate overlap on current obj_x: x-overlap AND player_bottom > OBJ_TOP.
//    - Overlap -> HIT.
//    - Else next = obj_count + step, 12-bit sum, saturated at PASS_END.
//    - If next == PASS_END -> WRAP, obj_count = PASS_END.
//    - Without a tick, all registers hold.
//  - WRAP: exactly one clk, regardless of frame_tick.
//    - obj_count = PASS_END for exactly one clk.
//    - Then obj_count=0, pass_count+1 (sat 255), return to RUN.
//    - A frame_tick arriving in WRAP is dropped.
//  - HIT: one clk.
//    - hit=1 on this clk only.
//    - obj_count=0, pass_count=0, step=STEP, hold counter=0.
//    - Then go to HOLD.
//  - HOLD: count frame_ticks; after HOLD_FRAMES ticks return to RUN with obj_count=0.
//  - Simultaneous overlap and saturation on one tick: collision wins (HIT, no WRAP).
//  - Overlap test:
//    - x-overlap = (obj_x < PLAYER_X+PLAYER_W) && (obj_x+OBJ_W > PLAYER_X).
//    - Compare signed; a negative obj_x (obstacle off left edge) never overlaps when obj_x+OBJ_W <= PLAYER_X.
//  - start outside IDLE is ignored.
//  - All outputs registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  - OBSTACLE_SPEEDUP_EN defined: step += 1 on each WRAP exit, capped at MAX_STEP; restored to STEP on HIT.
//  - OBSTACLE_SPEEDUP_EN undefined: step is constant STEP; MAX_STEP unused.
// STRUCTURE
//  - game_pkg holds:
//    - obstacle state enum.
//    - PASS_END, screen width/height constants.
//    - Shared 11-bit coordinate typedef.
//  - Sub-module aabb_overlap (combinational box-overlap test) is reused by later obstacle types.
//  - FSM, counters and step register are local.
// TESTING
//  - reset then start, 695 frame_ticks, player_bottom=400: obj_count holds 695 for exactly 1 clk, then 0; pass_count=1; hit never asserts.
//  - STEP=4, ticks from 692: obj_count 692 -> 695 (saturate) -> WRAP -> 0.
//  - player_bottom=450, obstacle reaches obj_x=99: hit is a 1-clk pulse; obj_count=0; pass_count=0; 60 ticks frozen; then RUN.
//  - Overlap on the same tick obj_count would saturate: hit=1, obj_count never shows 695.
//  - Async reset mid-HOLD and mid-WRAP: outputs zero immediately; IDLE; start required to resume.
//  - OBSTACLE_SPEEDUP_EN, MAX_STEP=3: pass durations 695, 348, 232, 232 ticks; after hit, step=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared obstacle FSM states, screen constants and coordinate type.
package game_pkg;
    typedef enum logic [2:0] {IDLE, RUN, WRAP, HIT, HOLD} obs_state_t;
    typedef logic [10:0] coord_t;
    localparam int PASS_END = 695;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
endpackage

// File: rtl/aabb_overlap.sv
// aabb_overlap: combinational test of two half-open signed boxes [x0,x1) x [y0,y1).
module aabb_overlap (
    input  logic signed [11:0] a_x0,
    input  logic signed [11:0] a_x1,
    input  logic signed [11:0] a_y0,
    input  logic signed [11:0] a_y1,
    input  logic signed [11:0] b_x0,
    input  logic signed [11:0] b_x1,
    input  logic signed [11:0] b_y0,
    input  logic signed [11:0] b_y1,
    output logic               overlap
);
    assign overlap = (a_x0 < b_x1) && (a_x1 > b_x0) && (a_y0 < b_y1) && (a_y1 > b_y0);
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: scrolls one obstacle per frame, flags pass wrap and player hits.
// OBSTACLE_SPEEDUP_EN: step grows by one per completed pass up to MAX_STEP.
module obstacle_scroller
    import game_pkg::*;
#(
    parameter int STEP        = 1,
    parameter int MAX_STEP    = 8,
    parameter int X_START     = SCREEN_W,
    parameter int OBJ_W       = 20,
    parameter int OBJ_TOP     = 440,
    parameter int PLAYER_X    = 80,
    parameter int PLAYER_W    = 20,
    parameter int HOLD_FRAMES = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         start,
    input  logic [9:0]   player_bottom,
    output coord_t       obj_count,
    output coord_t       obj_x,
    output logic         hit,
    output logic [7:0]   pass_count,
    output logic         busy
);
    localparam coord_t PASS_C = coord_t'(PASS_END);
    localparam coord_t STEP_C = coord_t'(STEP);
    // without speedup the cap never exceeds STEP, so step stays constant
`ifdef OBSTACLE_SPEEDUP_EN
    localparam coord_t CAP_C = coord_t'(MAX_STEP);
`else
    localparam coord_t CAP_C = coord_t'(MAX_STEP < STEP ? MAX_STEP : STEP);
`endif
    obs_state_t state, state_n;
    coord_t count_n, step, step_n, nxt;
    logic [7:0] pass_n, hold_cnt, hold_n;
    logic [11:0] sum;
    logic signed [11:0] sx;
    logic overlap;
    assign sx = 12'(X_START) - {1'b0, obj_count};
    assign obj_x = sx[10:0];
    assign hit = state == HIT;
    assign busy = state == RUN || state == WRAP;
    assign sum = {1'b0, obj_count} + {1'b0, step};
    assign nxt = (sum >= {1'b0, PASS_C}) ? PASS_C : sum[10:0];
    // obstacle extends downward without bound: any bottom below OBJ_TOP collides
    aabb_overlap u_overlap (
        .a_x0(sx),
        .a_x1(sx + 12'(OBJ_W)),
        .a_y0(12'(OBJ_TOP)),
        .a_y1(12'h7FF),
        .b_x0(12'(PLAYER_X)),
        .b_x1(12'(PLAYER_X + PLAYER_W)),
        .b_y0({2'b0, player_bottom} - 12'd1),
        .b_y1({2'b0, player_bottom}),
        .overlap(overlap)
    );
    always_comb begin
        state_n = state;
        count_n = obj_count;
        pass_n  = pass_count;
        step_n  = step;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                count_n = '0;
                state_n = start ? RUN : IDLE;
            end
            RUN: if (frame_tick) begin
                if (overlap) begin
                    state_n = HIT;
                    count_n = '0;
                    pass_n  = '0;
                    step_n  = STEP_C;
                    hold_n  = '0;
                end else begin
                    count_n = nxt;
                    state_n = (nxt == PASS_C) ? WRAP : RUN;
                end
            end
            WRAP: begin
                state_n = RUN;
                count_n = '0;
                pass_n  = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
                step_n  = (step >= CAP_C) ? step : step + coord_t'(1);
            end
            HIT: state_n = HOLD;
            HOLD: if (frame_tick) begin
                hold_n  = (hold_cnt == 8'(HOLD_FRAMES - 1)) ? 8'd0 : hold_cnt + 8'd1;
                state_n = (hold_cnt == 8'(HOLD_FRAMES - 1)) ? RUN : HOLD;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            obj_count  <= '0;
            pass_count <= '0;
            step       <= STEP_C;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            obj_count  <= count_n;
            pass_count <= pass_n;
            step       <= step_n;
            hold_cnt   <= hold_n;
        end
    end
endmodule
